// File: rtl/stage_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, redirect input and
// the valid/ready entry stream toward decode.
interface stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pcsub4;
  logic [31:0] out_pcadd4;
  logic [31:0] out_pcadd8;
  logic        out_adel;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output out_valid, out_instruction, out_pc, out_pcsub4, out_pcadd4,
           out_pcadd8, out_adel,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  out_valid, out_instruction, out_pc, out_pcsub4, out_pcadd4,
           out_pcadd8, out_adel,
    output out_ready
  );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight
// and buffers returned words with their PC family in a small FIFO for decode.
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  stage_fetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcsub4;
    logic [31:0] pcadd4;
    logic [31:0] pcadd8;
    logic        adel;
  } entry_t;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   req_pc, req_pc_nxt;
  logic          started;
  logic [AW:0]   count;
  logic [AW-1:0] head, tail;
  entry_t        mem [DEPTH];

  logic [AW+1:0] occ;
  logic          space, aligned, flush, issue, push, pop;
  logic [31:0]   push_pc, push_instr;
  logic          push_adel;
  entry_t        push_entry;

  // Occupancy counts the outstanding request; a same-cycle pop gives no credit.
  always_comb begin
    occ     = {1'b0, count} + (AW+2)'(state == WAIT);
    space   = occ < (AW+2)'(DEPTH);
    aligned = fetch_pc[1:0] == 2'b00;
    flush   = bus.redirect;
    pop     = (count != '0) && bus.out_ready;
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    issue        = 1'b0;
    push         = 1'b0;
    push_pc      = '0;
    push_instr   = '0;
    push_adel    = 1'b0;

    case (state)
      IDLE: begin
        if (!flush && started && space) begin
          if (aligned) begin
            issue = 1'b1;
          end else begin
            push      = 1'b1;
            push_pc   = fetch_pc;
            push_adel = 1'b1;
            state_nxt = HALT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt = bus.imem_ack ? IDLE : DISCARD;
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          push_pc    = req_pc;
          push_instr = bus.imem_rdata;
          // Back-to-back issue; a misaligned PC is left for IDLE to report.
          if (started && space && aligned) issue = 1'b1;
          else                             state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (bus.imem_ack) state_nxt = IDLE;
      end
      HALT: begin
        if (flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (issue) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
      req_pc_nxt   = fetch_pc;
      state_nxt    = WAIT;
    end
    if (flush) fetch_pc_nxt = bus.redirect_pc;
  end

  always_comb begin
    push_entry.instr  = push_instr;
    push_entry.pc     = push_pc;
    push_entry.pcsub4 = push_pc - 32'd4;
    push_entry.pcadd4 = push_pc + 32'd4;
    push_entry.pcadd8 = push_pc + 32'd8;
    push_entry.adel   = push_adel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      started  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      started  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    bus.imem_req        = issue;
    bus.imem_addr       = issue ? fetch_pc : '0;
    bus.out_valid       = count != '0;
    bus.out_instruction = mem[head].instr;
    bus.out_pc          = mem[head].pc;
    bus.out_pcsub4      = mem[head].pcsub4;
    bus.out_pcadd4      = mem[head].pcadd4;
    bus.out_pcadd8      = mem[head].pcadd8;
    bus.out_adel        = mem[head].adel;
  end

  a_ack_in_flight: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_ack |-> (state == WAIT || state == DISCARD));

endmodule

// File: tb/tb_stage_fetch.sv
// Directed cycle-by-cycle bench for stage_fetch: streaming, stall, redirect,
// address-error halt, PC wrap and asynchronous reset.
module tb_stage_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_fetch_if bus_if ();

  stage_fetch #(.RESET_PC(32'hBFC0_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_adel;
  } vec_t;

  vec_t tbl [16];

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, compare just after, DUT updates at rising edge.
  task automatic cyc(input logic ack, input logic [31:0] rdata, input logic redir,
                     input logic [31:0] rpc, input logic ready, input logic exp_req,
                     input logic [31:0] exp_addr, input logic exp_valid,
                     input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                     input logic exp_adel);
    @(negedge clk);
    bus_if.imem_ack    = ack;
    bus_if.imem_rdata  = rdata;
    bus_if.redirect    = redir;
    bus_if.redirect_pc = rpc;
    bus_if.out_ready   = ready;
    #1;
    chk("imem_req", 32'(bus_if.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus_if.imem_addr, exp_addr);
    chk("out_valid", 32'(bus_if.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_pc", bus_if.out_pc, exp_pc);
      chk("out_instruction", bus_if.out_instruction, exp_instr);
      chk("out_pcsub4", bus_if.out_pcsub4, exp_pc - 32'd4);
      chk("out_pcadd4", bus_if.out_pcadd4, exp_pc + 32'd4);
      chk("out_pcadd8", bus_if.out_pcadd8, exp_pc + 32'd8);
      chk("out_adel", 32'(bus_if.out_adel), 32'(exp_adel));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".imem_req"}, 32'(bus_if.imem_req), 32'd0);
    chk({tag, ".imem_addr"}, bus_if.imem_addr, 32'd0);
    chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, ".out_instruction"}, bus_if.out_instruction, 32'd0);
    chk({tag, ".out_pc"}, bus_if.out_pc, 32'd0);
    chk({tag, ".out_pcsub4"}, bus_if.out_pcsub4, 32'd0);
    chk({tag, ".out_pcadd4"}, bus_if.out_pcadd4, 32'd0);
    chk({tag, ".out_pcadd8"}, bus_if.out_pcadd8, 32'd0);
    chk({tag, ".out_adel"}, 32'(bus_if.out_adel), 32'd0);
  endtask

  initial begin
    //           ack rdata         rd rpc  rdy req addr          vld pc            instr         adel
    tbl[0]  = '{0, 32'h0,          0, 0,   1,  1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         0};
    tbl[1]  = '{1, 32'h1111_0000,  0, 0,   1,  1, 32'hBFC0_0004, 0, 32'h0,         32'h0,         0};
    tbl[2]  = '{1, 32'h1111_0001,  0, 0,   1,  0, 32'h0,         1, 32'hBFC0_0000, 32'h1111_0000, 0};
    tbl[3]  = '{0, 32'h0,          0, 0,   1,  1, 32'hBFC0_0008, 1, 32'hBFC0_0004, 32'h1111_0001, 0};
    tbl[4]  = '{1, 32'h1111_0002,  0, 0,   1,  1, 32'hBFC0_000C, 0, 32'h0,         32'h0,         0};
    tbl[5]  = '{1, 32'h1111_0003,  0, 0,   1,  0, 32'h0,         1, 32'hBFC0_0008, 32'h1111_0002, 0};
    tbl[6]  = '{0, 32'h0,          0, 0,   1,  1, 32'hBFC0_0010, 1, 32'hBFC0_000C, 32'h1111_0003, 0};
    tbl[7]  = '{1, 32'h1111_0004,  0, 0,   0,  1, 32'hBFC0_0014, 0, 32'h0,         32'h0,         0};
    tbl[8]  = '{1, 32'h1111_0005,  0, 0,   0,  0, 32'h0,         1, 32'hBFC0_0010, 32'h1111_0004, 0};
    tbl[9]  = '{0, 32'h0,          0, 0,   0,  0, 32'h0,         1, 32'hBFC0_0010, 32'h1111_0004, 0};
    tbl[10] = '{0, 32'h0,          0, 0,   0,  0, 32'h0,         1, 32'hBFC0_0010, 32'h1111_0004, 0};
    tbl[11] = '{0, 32'h0,          0, 0,   1,  0, 32'h0,         1, 32'hBFC0_0010, 32'h1111_0004, 0};
    tbl[12] = '{0, 32'h0,          0, 0,   1,  1, 32'hBFC0_0018, 1, 32'hBFC0_0014, 32'h1111_0005, 0};
    tbl[13] = '{1, 32'h1111_0006,  0, 0,   1,  1, 32'hBFC0_001C, 0, 32'h0,         32'h0,         0};
    tbl[14] = '{0, 32'h0,          0, 0,   1,  0, 32'h0,         1, 32'hBFC0_0018, 32'h1111_0006, 0};
    tbl[15] = '{1, 32'h1111_0007,  0, 0,   1,  1, 32'hBFC0_0020, 0, 32'h0,         32'h0,         0};

    reset              = 1'b0;
    bus_if.imem_ack    = 1'b0;
    bus_if.imem_rdata  = '0;
    bus_if.redirect    = 1'b0;
    bus_if.redirect_pc = '0;
    bus_if.out_ready   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b1;

    // Streaming with 1-cycle memory, then a decode stall and drain
    for (int i = 0; i < 16; i++)
      cyc(tbl[i].ack, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].ready,
          tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_valid, tbl[i].exp_pc,
          tbl[i].exp_instr, tbl[i].exp_adel);

    // Redirect while WAIT; the late ack must be dropped
    cyc(0, 0,     1, 32'h0000_0100, 1, 0, 0, 1, 32'hBFC0_001C, 32'h1111_0007, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, JUNK,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 1, 32'h0000_0100, 0, 0, 0, 0);
    cyc(1, 32'h2222_0100, 0, 0, 1, 1, 32'h0000_0104, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h2222_0100, 0);

    // Redirect coincident with ack
    cyc(1, JUNK,  1, 32'h0000_0180, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 1, 32'h0000_0180, 0, 0, 0, 0);
    cyc(1, 32'h3333_0180, 0, 0, 1, 1, 32'h0000_0184, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 1, 32'h0000_0180, 32'h3333_0180, 0);

    // Misaligned redirect -> address-error entry, halt, resume on redirect
    cyc(1, JUNK,  1, 32'h0000_0102, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 1, 32'h0000_0102, 32'h0, 1);
    cyc(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     1, 32'h0000_0200, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 1, 32'h0000_0200, 0, 0, 0, 0);
    cyc(1, 32'h4444_0200, 0, 0, 1, 1, 32'h0000_0204, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 1, 32'h0000_0200, 32'h4444_0200, 0);

    // Fetch PC wrap at the top of the address space
    cyc(1, JUNK,  1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cyc(1, 32'h5555_0000, 0, 0, 1, 1, 32'h0000_0000, 0, 0, 0, 0);
    cyc(1, 32'h5555_0001, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h5555_0000, 0);
    cyc(0, 0,     0, 0, 1, 1, 32'h0000_0004, 1, 32'h0000_0000, 32'h5555_0001, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h5555_0002, 0, 0, 1, 1, 32'h0000_0008, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 1, 32'h0000_0004, 32'h5555_0002, 0);

    // Asynchronous reset mid-WAIT with a valid head entry
    reset = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("hold");
    reset = 1'b1;
    cyc(0, 0,     0, 0, 1, 1, 32'hBFC0_0000, 0, 0, 0, 0);
    cyc(1, 32'h6666_0000, 0, 0, 1, 1, 32'hBFC0_0004, 0, 0, 0, 0);
    cyc(0, 0,     0, 0, 1, 0, 0, 1, 32'hBFC0_0000, 32'h6666_0000, 0);
    chk("first.pcsub4", bus_if.out_pcsub4, 32'hBFBF_FFFC);
    chk("first.pcadd8", bus_if.out_pcadd8, 32'hBFC0_0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
